// File: rtl/lfsr_checker_if.sv
// Sample and status bundle between a PRBS receive path and the LFSR checker.
// The master drives samples and error-clear; the slave (checker) reports lock and error state.
interface lfsr_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic             In_Valid;
  logic [3:0]       In_Data;
  logic             Clr_Err;
  logic             Locked;
  logic             Err_Pulse;
  logic [ERR_W-1:0] Err_Count;
  logic [3:0]       Expected;

  modport master (
    output In_Valid,
    output In_Data,
    output Clr_Err,
    input  Locked,
    input  Err_Pulse,
    input  Err_Count,
    input  Expected
  );

  modport slave (
    input  In_Valid,
    input  In_Data,
    input  Clr_Err,
    output Locked,
    output Err_Pulse,
    output Err_Count,
    output Expected
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 4-bit LFSR stream: seeds from the data, locks after
// LOCK_CNT consistent words, then flywheels and counts mismatches until LOSS_CNT in a row.
module lfsr_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 2,
  parameter int unsigned ERR_W    = 8
) (
  input logic           Clk,
  input logic           Rst,
  lfsr_checker_if.slave bus
);

  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW  = $clog2(LOSS_CNT + 1);
  localparam logic [MatchW-1:0] LockCntV = MatchW'(LOCK_CNT);
  localparam logic [MissW-1:0]  LossCntV = MissW'(LOSS_CNT);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e            state_q, state_d;
  logic [3:0]        pred_q, pred_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [MissW-1:0]  miss_q, miss_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

  logic              samp_zero;
  logic              samp_hit;
  logic [MatchW-1:0] match_upd;
  logic [MissW-1:0]  miss_upd;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    return {v[2:0], v[1] ^ v[3]};
  endfunction

  // Candidate counter updates for the current sample; the FSM decides which one is kept.
  always_comb begin
    samp_zero = (bus.In_Data == 4'h0);
    samp_hit  = (bus.In_Data == pred_q);
    if (samp_zero) begin
      match_upd = '0;
    end else if (samp_hit) begin
      match_upd = match_q + 1'b1;
    end else begin
      match_upd = MatchW'(1);
    end
    miss_upd = samp_hit ? '0 : miss_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StSearch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.In_Valid) begin
      unique case (state_q)
        StSearch: if (match_upd == LockCntV) state_d = StLocked;
        StLocked: if (!samp_hit && (miss_upd == LossCntV)) state_d = StSearch;
        default:  state_d = StSearch;
      endcase
    end
  end

  always_comb begin
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    if (bus.In_Valid) begin
      unique case (state_q)
        StSearch: begin
          // A zero word is the LFSR lock-up state; it never seeds a prediction.
          pred_d  = samp_zero ? 4'h0 : nxt(bus.In_Data);
          match_d = match_upd;
          if (state_d == StLocked) miss_d = '0;
        end
        StLocked: begin
          pred_d = nxt(pred_q);
          miss_d = miss_upd;
          if (!samp_hit) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
          if (state_d == StSearch) begin
            match_d = '0;
            miss_d  = '0;
          end
        end
        default: ;
      endcase
    end
    if (bus.Clr_Err) err_cnt_d = '0;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pred_q      <= 4'h0;
      match_q     <= '0;
      miss_q      <= '0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.Locked    = (state_q == StLocked);
  assign bus.Err_Pulse = err_pulse_q;
  assign bus.Err_Count = err_cnt_q;
  assign bus.Expected  = pred_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed scenarios plus randomized traffic against a
// behavioural model, on a default instance and a narrow-counter / long-loss instance.
module tb_lfsr_checker;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  lfsr_checker_if #(.ERR_W(8)) b0 ();
  lfsr_checker_if #(.ERR_W(2)) b1 ();

  lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut0 (.Clk(clk), .Rst(rst0), .bus(b0));
  lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(8), .ERR_W(2)) dut1 (.Clk(clk), .Rst(rst1), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state per instance.
  int          p_lock [2] = '{3, 3};
  int          p_loss [2] = '{2, 8};
  int          p_max  [2] = '{255, 3};
  bit          m_locked [2];
  bit          m_pulse  [2];
  int          m_cnt    [2];
  int          m_match  [2];
  int          m_miss   [2];
  logic [3:0]  m_pred   [2];

  function automatic logic [3:0] lfsr_next(input logic [3:0] v);
    return {v[2], v[1], v[0], v[1] ^ v[3]};
  endfunction

  task automatic model_reset(input int k);
    m_locked[k] = 0; m_pulse[k] = 0; m_cnt[k] = 0;
    m_match[k] = 0; m_miss[k] = 0; m_pred[k] = 4'h0;
  endtask

  task automatic model_update(input int k, input bit v, input logic [3:0] d, input bit c,
                              input bit r);
    if (r) begin
      model_reset(k);
      return;
    end
    m_pulse[k] = 0;
    if (v) begin
      if (!m_locked[k]) begin
        if (d == 4'h0) begin
          m_match[k] = 0;
          m_pred[k]  = 4'h0;
        end else begin
          m_match[k] = (d == m_pred[k]) ? m_match[k] + 1 : 1;
          m_pred[k]  = lfsr_next(d);
        end
        if (m_match[k] == p_lock[k]) begin
          m_locked[k] = 1;
          m_miss[k]   = 0;
        end
      end else begin
        if (d != m_pred[k]) begin
          m_pulse[k] = 1;
          if (m_cnt[k] < p_max[k]) m_cnt[k]++;
          m_miss[k]++;
          if (m_miss[k] == p_loss[k]) begin
            m_locked[k] = 0;
            m_match[k]  = 0;
            m_miss[k]   = 0;
          end
        end else begin
          m_miss[k] = 0;
        end
        m_pred[k] = lfsr_next(m_pred[k]);
      end
    end
    if (c) m_cnt[k] = 0;
  endtask

  // One clock on instance id; the other instance idles.
  task automatic step(input int id, input bit v, input logic [3:0] d, input bit c, input bit r);
    if (id == 0) begin
      b0.In_Valid = v; b0.In_Data = d; b0.Clr_Err = c; rst0 = r;
      b1.In_Valid = 1'b0; b1.Clr_Err = 1'b0; rst1 = 1'b0;
    end else begin
      b1.In_Valid = v; b1.In_Data = d; b1.Clr_Err = c; rst1 = r;
      b0.In_Valid = 1'b0; b0.Clr_Err = 1'b0; rst0 = 1'b0;
    end
    @(posedge clk);
    #1;
    model_update(id, v, d, c, r);
    model_update(1 - id, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic sample(input int id, output logic l, output logic p, output int c,
                        output logic [3:0] e);
    if (id == 0) begin
      l = b0.Locked; p = b0.Err_Pulse; c = int'(b0.Err_Count); e = b0.Expected;
    end else begin
      l = b1.Locked; p = b1.Err_Pulse; c = int'(b1.Err_Count); e = b1.Expected;
    end
  endtask

  task automatic test_reset();
    logic l, p; int c; logic [3:0] e;
    b0.In_Valid = 1'b1; b0.In_Data = 4'h8; b0.Clr_Err = 1'b0;
    b1.In_Valid = 1'b1; b1.In_Data = 4'h8; b1.Clr_Err = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset(0); model_reset(1);
    for (int k = 0; k < 2; k++) begin
      sample(k, l, p, c, e);
      n_cmp++;
      if ({l, p, c, e} !== {1'b0, 1'b0, 32'd0, 4'h0}) begin
        n_err++;
        $display("FAIL reset[%0d]: got L=%b P=%b C=%0d E=%h, want all 0", k, l, p, c, e);
      end
    end
  endtask

  task automatic test_lock();
    step(0, 1, 4'h8, 0, 0);
    step(0, 1, 4'h1, 0, 0);
    n_cmp++;
    if (b0.Locked !== 1'b0) begin
      n_err++; $display("FAIL lock_early: Locked=%b want 0", b0.Locked);
    end
    step(0, 1, 4'h2, 0, 0);
    n_cmp++;
    if (b0.Locked !== 1'b1) begin
      n_err++; $display("FAIL lock_rise: Locked=%b want 1", b0.Locked);
    end
    n_cmp++;
    if (b0.Expected !== 4'h5) begin
      n_err++; $display("FAIL lock_expected: Expected=%h want 5", b0.Expected);
    end
  endtask

  task automatic test_error();
    step(0, 1, 4'h5, 0, 0);
    step(0, 1, 4'h7, 0, 0);
    n_cmp++;
    if ({b0.Err_Pulse, b0.Err_Count, b0.Locked} !== {1'b1, 8'd1, 1'b1}) begin
      n_err++;
      $display("FAIL error_hit: P=%b C=%0d L=%b want P=1 C=1 L=1",
               b0.Err_Pulse, b0.Err_Count, b0.Locked);
    end
    step(0, 1, 4'h4, 0, 0);
    n_cmp++;
    if (b0.Err_Pulse !== 1'b0) begin
      n_err++; $display("FAIL error_pulse_width: P=%b want 0", b0.Err_Pulse);
    end
    step(0, 1, 4'h8, 0, 0);
    n_cmp++;
    if ({b0.Expected, b0.Locked, b0.Err_Count} !== {4'h1, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL error_flywheel: E=%h L=%b C=%0d want E=1 L=1 C=1",
               b0.Expected, b0.Locked, b0.Err_Count);
    end
  endtask

  task automatic test_loss();
    step(0, 1, 4'h3, 0, 0);
    n_cmp++;
    if ({b0.Locked, b0.Err_Pulse} !== 2'b11) begin
      n_err++; $display("FAIL loss_first: L=%b P=%b want L=1 P=1", b0.Locked, b0.Err_Pulse);
    end
    step(0, 1, 4'h3, 0, 0);
    n_cmp++;
    if ({b0.Locked, b0.Err_Pulse, b0.Err_Count} !== {1'b0, 1'b1, 8'd3}) begin
      n_err++;
      $display("FAIL loss_drop: L=%b P=%b C=%0d want L=0 P=1 C=3",
               b0.Locked, b0.Err_Pulse, b0.Err_Count);
    end
    step(0, 1, 4'h5, 0, 0);
    step(0, 1, 4'hA, 0, 0);
    step(0, 1, 4'h4, 0, 0);
    n_cmp++;
    if ({b0.Locked, b0.Expected, b0.Err_Count} !== {1'b1, 4'h8, 8'd3}) begin
      n_err++;
      $display("FAIL loss_relock: L=%b E=%h C=%0d want L=1 E=8 C=3",
               b0.Locked, b0.Expected, b0.Err_Count);
    end
  endtask

  task automatic test_zero_word();
    step(0, 0, 4'h0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h0, 0, 0);
    n_cmp++;
    if ({b0.Locked, b0.Expected} !== {1'b0, 4'h0}) begin
      n_err++; $display("FAIL zero_search: L=%b E=%h want L=0 E=0", b0.Locked, b0.Expected);
    end
    step(0, 1, 4'h2, 0, 0);
    step(0, 1, 4'h5, 0, 0);
    step(0, 1, 4'hA, 0, 0);
    n_cmp++;
    if ({b0.Locked, b0.Expected} !== {1'b1, 4'h4}) begin
      n_err++; $display("FAIL zero_lock: L=%b E=%h want L=1 E=4", b0.Locked, b0.Expected);
    end
  endtask

  task automatic test_saturate();
    step(1, 0, 4'h0, 0, 1);
    step(1, 1, 4'h8, 0, 0);
    step(1, 1, 4'h1, 0, 0);
    step(1, 1, 4'h2, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, m_pred[1] ^ 4'h6, 0, 0);
      n_cmp++;
      if (int'(b1.Err_Count) != ((i < 3) ? i : 3) || b1.Err_Pulse !== 1'b1) begin
        n_err++;
        $display("FAIL sat_count[%0d]: C=%0d P=%b want C=%0d P=1",
                 i, b1.Err_Count, b1.Err_Pulse, (i < 3) ? i : 3);
      end
      step(1, 1, m_pred[1], 0, 0);
    end
    step(1, 1, m_pred[1] ^ 4'h9, 1, 0);
    n_cmp++;
    if ({b1.Err_Count, b1.Err_Pulse, b1.Locked} !== {2'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL sat_clear_wins: C=%0d P=%b L=%b want C=0 P=1 L=1",
               b1.Err_Count, b1.Err_Pulse, b1.Locked);
    end
  endtask

  task automatic test_idle_toggle();
    step(0, 0, 4'h0, 0, 1);
    step(0, 1, 4'h8, 0, 0);
    step(0, 1, 4'h1, 0, 0);
    step(0, 1, 4'h2, 0, 0);
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) step(0, 1, m_pred[0], 0, 0);
      else            step(0, 0, 4'($urandom), 0, 0);
      n_cmp++;
      if ({b0.Locked, b0.Err_Pulse, b0.Err_Count, b0.Expected} !==
          {1'b1, 1'b0, 8'd0, m_pred[0]}) begin
        n_err++;
        $display("FAIL idle_hold[%0d]: L=%b P=%b C=%0d E=%h want L=1 P=0 C=0 E=%h",
                 i, b0.Locked, b0.Err_Pulse, b0.Err_Count, b0.Expected, m_pred[0]);
      end
    end
    step(0, 1, 4'h3, 0, 0);
    step(0, 1, 4'($urandom), 1, 1);
    n_cmp++;
    if ({b0.Locked, b0.Err_Pulse, b0.Err_Count, b0.Expected} !== 14'd0) begin
      n_err++;
      $display("FAIL midstream_reset: L=%b P=%b C=%0d E=%h want all 0",
               b0.Locked, b0.Err_Pulse, b0.Err_Count, b0.Expected);
    end
  endtask

  task automatic test_random(input int id, input int n);
    logic l, p; int c; logic [3:0] e;
    bit v, clr, r;
    logic [3:0] d;
    for (int i = 0; i < n; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      d   = ($urandom_range(0, 4) != 0 && m_pred[id] != 4'h0) ? m_pred[id] : 4'($urandom);
      clr = ($urandom_range(0, 31) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(id, v, d, clr, r);
      sample(id, l, p, c, e);
      n_cmp++;
      if (l !== 1'(m_locked[id]) || p !== 1'(m_pulse[id]) || c != m_cnt[id] ||
          e !== m_pred[id]) begin
        n_err++;
        $display("FAIL random[%0d.%0d]: got L=%b P=%b C=%0d E=%h want L=%b P=%b C=%0d E=%h",
                 id, i, l, p, c, e, m_locked[id], m_pulse[id], m_cnt[id], m_pred[id]);
      end
    end
  endtask

  initial begin
    b0.In_Valid = 1'b0; b0.In_Data = 4'h0; b0.Clr_Err = 1'b0;
    b1.In_Valid = 1'b0; b1.In_Data = 4'h0; b1.Clr_Err = 1'b0;
    test_reset();
    test_lock();
    test_error();
    test_loss();
    test_zero_word();
    test_saturate();
    test_idle_toggle();
    test_random(0, 600);
    test_random(1, 600);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
